block_cache: RTL and testbench

- Small direct-mapped L1 cache for voxel block lookups.
- Sits directly upstream of the chunk ROM (L3 store). It accepts BlockPos queries from the ray traversal unit and returns BlockType.
- Hits are served from local storage. Misses issue one read to the chunk ROM and fill the line.
- Out-of-chunk positions short-circuit to air without touching L3.

---
 rtl/block_cache_pkg.sv | 35 +++
 rtl/block_cache_if.sv | 24 ++
 rtl/block_cache_array.sv | 47 ++++
 rtl/block_cache.sv | 147 ++++++++++++++
 tb/tb_block_cache.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/block_cache_pkg.sv
// Shared types and constants for the voxel block cache and its chunk ROM interface.
package block_cache_pkg;

  localparam int COORD_WIDTH = 8;
  localparam int CHUNK_WIDTH = 16;
  localparam int BLOCK_WIDTH = 5;

  typedef logic [BLOCK_WIDTH-1:0] block_type_t;

  typedef struct packed {
    logic signed [COORD_WIDTH-1:0] x;
    logic signed [COORD_WIDTH-1:0] y;
    logic signed [COORD_WIDTH-1:0] z;
  } block_pos_t;

  localparam block_type_t BLOCK_AIR = 5'd0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    MISS_WAIT = 2'd2
  } cache_state_t;

  localparam logic signed [COORD_WIDTH-1:0] CHUNK_LIMIT = COORD_WIDTH'(CHUNK_WIDTH);

  // The chunk spans [-CHUNK_WIDTH, CHUNK_WIDTH) on every axis.
  function automatic logic coord_oob(input logic signed [COORD_WIDTH-1:0] c);
    return (c >= CHUNK_LIMIT) || (c < -CHUNK_LIMIT);
  endfunction

  function automatic logic pos_is_oob(input block_pos_t p);
    return coord_oob(p.x) || coord_oob(p.y) || coord_oob(p.z);
  endfunction

endpackage

// File: rtl/block_cache_if.sv
// Request/response and chunk ROM signals between the ray traversal unit, the cache and L3.
interface block_cache_if;
  import block_cache_pkg::*;

  logic        req_valid;
  logic        req_ready;
  block_pos_t  req_pos;
  logic        resp_valid;
  block_type_t resp_block;
  logic        resp_hit;
  block_pos_t  l3_addr;
  logic        l3_read_enable;
  block_type_t l3_out;

  modport slave (
    input  req_valid, req_pos, l3_out,
    output req_ready, resp_valid, resp_block, resp_hit, l3_addr, l3_read_enable
  );

  modport master (
    output req_valid, req_pos, l3_out,
    input  req_ready, resp_valid, resp_block, resp_hit, l3_addr, l3_read_enable
  );
endinterface

// File: rtl/block_cache_array.sv
// Direct-mapped line storage: combinational read, synchronous write, valid bits with one-cycle flush.
module block_cache_array
  import block_cache_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  flush,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output block_pos_t            rd_tag,
  output block_type_t           rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  block_pos_t            wr_tag,
  input  block_type_t           wr_data
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0] valid_r;
  block_pos_t       tag_r  [LINES];
  block_type_t      data_r [LINES];

  assign rd_valid = valid_r[rd_index];
  assign rd_tag   = tag_r[rd_index];
  assign rd_data  = data_r[rd_index];

  // Valid bits: cleared by reset or flush, set by a line fill
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_r <= '0;
    end else if (flush) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_index] <= 1'b1;
    end
  end

  // Tag and data payload; meaningless while the line is invalid, so no reset
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_r[wr_index]  <= wr_tag;
      data_r[wr_index] <= wr_data;
    end
  end
endmodule

// File: rtl/block_cache.sv
// Direct-mapped voxel block cache in front of the chunk ROM.
// Hits and out-of-chunk queries answer two cycles after accept; misses fetch the line from L3.
module block_cache
  import block_cache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int L3_LATENCY = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         flush,
  block_cache_if.slave bus
);
  localparam int K     = INDEX_BITS / 3;
  localparam int CNT_W = $clog2(L3_LATENCY + 2);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(L3_LATENCY);
  localparam logic [CNT_W-1:0] WAIT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] WAIT_ONE  = CNT_W'(1'b1);

  cache_state_t          state_r, state_s;
  block_pos_t            pos_r;
  logic [CNT_W-1:0]      wait_r, wait_s;
  logic                  drop_r, drop_s;
  logic                  resp_valid_r, resp_valid_s;
  logic                  resp_hit_r, resp_hit_s;
  block_type_t           resp_block_r, resp_block_s;
  logic                  l3_read_enable_r, l3_read_enable_s;
  block_pos_t            l3_addr_r, l3_addr_s;
  logic [INDEX_BITS-1:0] index_s;
  logic                  line_valid_s;
  block_pos_t            line_tag_s;
  block_type_t           line_data_s;
  logic                  oob_s, hit_s, fill_s, req_ready_s, accept_s;

  assign index_s     = {pos_r.z[K-1:0], pos_r.y[K-1:0], pos_r.x[K-1:0]};
  assign oob_s       = pos_is_oob(pos_r);
  assign hit_s       = line_valid_s && (line_tag_s == pos_r);
  assign req_ready_s = (state_r == IDLE) && !flush;
  assign accept_s    = bus.req_valid && req_ready_s;

  block_cache_array #(.INDEX_BITS(INDEX_BITS)) u_array (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .flush    (flush),
    .rd_index (index_s),
    .rd_valid (line_valid_s),
    .rd_tag   (line_tag_s),
    .rd_data  (line_data_s),
    .wr_en    (fill_s),
    .wr_index (index_s),
    .wr_tag   (pos_r),
    .wr_data  (bus.l3_out)
  );

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:      if (accept_s) state_s = LOOKUP; else state_s = IDLE;
      LOOKUP:    if (oob_s || hit_s) state_s = IDLE; else state_s = MISS_WAIT;
      MISS_WAIT: if (wait_r == WAIT_ZERO) state_s = IDLE; else state_s = MISS_WAIT;
      default:   state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, wait counter, drop flag and fill strobe
  always_comb begin
    resp_valid_s     = 1'b0;
    resp_hit_s       = 1'b0;
    resp_block_s     = resp_block_r;
    l3_read_enable_s = 1'b0;
    l3_addr_s        = l3_addr_r;
    wait_s           = wait_r;
    drop_s           = drop_r;
    fill_s           = 1'b0;
    case (state_r)
      IDLE: drop_s = 1'b0;
      LOOKUP: begin
        if (oob_s) begin
          resp_valid_s = 1'b1;
          resp_hit_s   = 1'b1;
          resp_block_s = BLOCK_AIR;
        end else if (hit_s) begin
          resp_valid_s = 1'b1;
          resp_hit_s   = 1'b1;
          resp_block_s = line_data_s;
        end else begin
          l3_read_enable_s = 1'b1;
          l3_addr_s        = pos_r;
          wait_s           = WAIT_LOAD;
        end
      end
      MISS_WAIT: begin
        if (wait_r == WAIT_ZERO) begin
          // A flush seen anywhere in the wait, including this edge, keeps the line out
          resp_valid_s = 1'b1;
          resp_block_s = bus.l3_out;
          fill_s       = !drop_r && !flush;
          drop_s       = 1'b0;
        end else begin
          wait_s = wait_r - WAIT_ONE;
          if (flush) drop_s = 1'b1; else drop_s = drop_r;
        end
      end
      default: drop_s = 1'b0;
    endcase
  end

  // Output, counter, drop flag and captured-request registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pos_r            <= '0;
      wait_r           <= WAIT_ZERO;
      drop_r           <= 1'b0;
      resp_valid_r     <= 1'b0;
      resp_hit_r       <= 1'b0;
      resp_block_r     <= BLOCK_AIR;
      l3_read_enable_r <= 1'b0;
      l3_addr_r        <= '0;
    end else begin
      if (accept_s) pos_r <= bus.req_pos;
      wait_r           <= wait_s;
      drop_r           <= drop_s;
      resp_valid_r     <= resp_valid_s;
      resp_hit_r       <= resp_hit_s;
      resp_block_r     <= resp_block_s;
      l3_read_enable_r <= l3_read_enable_s;
      l3_addr_r        <= l3_addr_s;
    end
  end

  assign bus.req_ready      = req_ready_s;
  assign bus.resp_valid     = resp_valid_r;
  assign bus.resp_hit       = resp_hit_r;
  assign bus.resp_block     = resp_block_r;
  assign bus.l3_read_enable = l3_read_enable_r;
  assign bus.l3_addr        = l3_addr_r;
endmodule

// File: tb/tb_block_cache.sv
// Randomized bench for block_cache against a transaction-level cache model with per-cycle checks.
module tb_block_cache;
  import block_cache_pkg::*;

  localparam int L3_LATENCY = 2;
  localparam int LINES      = 64;
  localparam int SIDE       = 4;

  logic clk_in;
  logic rst_in;
  logic flush;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  block_cache_if bus();

  block_cache #(.INDEX_BITS(6), .L3_LATENCY(L3_LATENCY)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .flush  (flush),
    .bus    (bus)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_in) cyc <= cyc + 1;

  // model state: cache contents and per-cycle expectations
  bit          m_valid [LINES];
  block_pos_t  m_tag   [LINES];
  block_type_t m_data  [LINES];
  bit          exp_rv [int];
  block_type_t exp_blk [int];
  bit          exp_hit [int];
  bit          exp_l3 [int];
  block_pos_t  addr_change [int];
  bit          busy [int];
  block_type_t l3_sched [int];
  block_pos_t  cur_addr;
  int          obs_cyc = -1;
  block_type_t obs_blk;
  logic        obs_hit;
  int          l3_count = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic block_pos_t mk(input int x, input int y, input int z);
    block_pos_t p;
    p.x = 8'(x);
    p.y = 8'(y);
    p.z = 8'(z);
    return p;
  endfunction

  function automatic block_type_t rom(input block_pos_t p);
    int v;
    if (p == mk(1, 2, 3)) return 5'd7;
    if (p == mk(5, 2, 3)) return 5'd9;
    if (p == mk(2, 2, 2)) return 5'd4;
    v = int'($signed(p.x)) * 3 + int'($signed(p.y)) * 5 + int'($signed(p.z)) * 7 + 11;
    return 5'(v & 31);
  endfunction

  function automatic bit m_oob(input block_pos_t p);
    int c [3];
    c[0] = int'($signed(p.x));
    c[1] = int'($signed(p.y));
    c[2] = int'($signed(p.z));
    for (int i = 0; i < 3; i++) if (c[i] >= CHUNK_WIDTH || c[i] < -CHUNK_WIDTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int wrap(input int v);
    return ((v % SIDE) + SIDE) % SIDE;
  endfunction

  function automatic int m_index(input block_pos_t p);
    return wrap(int'($signed(p.z))) * SIDE * SIDE + wrap(int'($signed(p.y))) * SIDE
           + wrap(int'($signed(p.x)));
  endfunction

  // chunk ROM: data valid L3_LATENCY cycles after the read strobe, garbage otherwise
  initial begin
    bus.l3_out = 5'd0;
    forever begin
      @(negedge clk_in); #1;
      if (l3_sched.exists(cyc)) bus.l3_out = l3_sched[cyc];
      else bus.l3_out = 5'($urandom);
      if (bus.l3_read_enable === 1'b1) l3_sched[cyc + L3_LATENCY] = rom(bus.l3_addr);
    end
  end

  // per-cycle compare against the model
  initial begin
    cur_addr = '0;
    forever begin
      @(negedge clk_in); #2;
      if (rst_in) cur_addr = '0;
      else if (addr_change.exists(cyc)) cur_addr = addr_change[cyc];
      chk("resp_valid", 64'(bus.resp_valid), 64'(exp_rv.exists(cyc)));
      if (exp_rv.exists(cyc)) begin
        chk("resp_block", 64'(bus.resp_block), 64'(exp_blk[cyc]));
        chk("resp_hit", 64'(bus.resp_hit), 64'(exp_hit[cyc]));
      end
      chk("l3_read_enable", 64'(bus.l3_read_enable), 64'(exp_l3.exists(cyc)));
      chk("l3_addr", 64'(bus.l3_addr), 64'(cur_addr));
      chk("req_ready", 64'(bus.req_ready), 64'(!busy.exists(cyc) && !flush));
      if (bus.resp_valid === 1'b1) begin
        obs_cyc = cyc;
        obs_blk = bus.resp_block;
        obs_hit = bus.resp_hit;
      end
      if (bus.l3_read_enable === 1'b1) l3_count++;
    end
  end

  task automatic start_req(input block_pos_t p, output int a, output int rc, output bit miss);
    int idx;
    @(negedge clk_in);
    bus.req_valid = 1'b1;
    bus.req_pos   = p;
    @(posedge clk_in); #1;
    bus.req_valid = 1'b0;
    bus.req_pos   = 24'($urandom);
    a    = cyc;
    idx  = m_index(p);
    miss = 1'b0;
    busy[a] = 1'b1;
    if (m_oob(p)) begin
      rc = a + 1;
      exp_rv[rc] = 1'b1; exp_blk[rc] = BLOCK_AIR; exp_hit[rc] = 1'b1;
    end else if (m_valid[idx] && m_tag[idx] == p) begin
      rc = a + 1;
      exp_rv[rc] = 1'b1; exp_blk[rc] = m_data[idx]; exp_hit[rc] = 1'b1;
    end else begin
      miss = 1'b1;
      rc = a + 2 + L3_LATENCY;
      exp_l3[a + 1] = 1'b1;
      addr_change[a + 1] = p;
      for (int k = a + 1; k < rc; k++) busy[k] = 1'b1;
      exp_rv[rc] = 1'b1; exp_blk[rc] = rom(p); exp_hit[rc] = 1'b0;
    end
  endtask

  // flush_off: cycle offset from the lookup cycle at which flush is pulsed (-1 = none)
  task automatic finish_req(input block_pos_t p, input int a, input int rc, input bit miss,
                            input int flush_off);
    bit drop = 1'b0;
    int idx  = m_index(p);
    for (int c = a; c < rc; c++) begin
      if (c - a == flush_off) begin
        flush = 1'b1;
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        if (c > a) drop = 1'b1;
      end else begin
        flush = 1'b0;
      end
      @(posedge clk_in); #1;
    end
    flush = 1'b0;
    if (miss && !drop) begin
      m_valid[idx] = 1'b1; m_tag[idx] = p; m_data[idx] = rom(p);
    end
  endtask

  task automatic req_check(input block_pos_t p, input int flush_off, input int e_blk,
                           input int e_hit, input int e_lat, input int e_pulses);
    int a, rc, p0;
    bit miss;
    obs_cyc = -1;
    p0 = l3_count;
    start_req(p, a, rc, miss);
    finish_req(p, a, rc, miss, flush_off);
    @(negedge clk_in); #3;
    chk("latency", 64'(obs_cyc - a + 1), 64'(e_lat));
    chk("dir_block", 64'(obs_blk), 64'(e_blk));
    chk("dir_hit", 64'(obs_hit), 64'(e_hit));
    chk("l3_pulses", 64'(l3_count - p0), 64'(e_pulses));
  endtask

  task automatic model_reset();
    for (int k = cyc; k < cyc + 64; k++) begin
      if (exp_rv.exists(k)) exp_rv.delete(k);
      if (exp_blk.exists(k)) exp_blk.delete(k);
      if (exp_hit.exists(k)) exp_hit.delete(k);
      if (exp_l3.exists(k)) exp_l3.delete(k);
      if (addr_change.exists(k)) addr_change.delete(k);
      if (busy.exists(k)) busy.delete(k);
    end
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int a, rc, off, gap;
    bit miss;
    block_pos_t p;
    int pool [12] = '{-17, -16, -1, 0, 1, 2, 3, 4, 5, 6, 15, 16};
    rst_in = 1'b1;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_pos = '0;
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;

    req_check(mk(1, 2, 3), -1, 7, 0, 5, 1);
    req_check(mk(1, 2, 3), -1, 7, 1, 2, 0);
    req_check(mk(5, 2, 3), -1, 9, 0, 5, 1);
    req_check(mk(1, 2, 3), -1, 7, 0, 5, 1);
    req_check(mk(CHUNK_WIDTH, 0, 0), -1, 0, 1, 2, 0);
    req_check(mk(0, -CHUNK_WIDTH - 1, 0), -1, 0, 1, 2, 0);
    req_check(mk(-CHUNK_WIDTH, 0, 0), -1, 27, 0, 5, 1);
    req_check(mk(2, 2, 2), 2, 4, 0, 5, 1);
    req_check(mk(2, 2, 2), -1, 4, 0, 5, 1);
    req_check(mk(1, 2, 3), -1, 7, 0, 5, 1);

    // asynchronous reset in the middle of a miss
    obs_cyc = -1;
    start_req(mk(7, 7, 7), a, rc, miss);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    @(negedge clk_in); #1;
    rst_in = 1'b1;
    model_reset();
    #1;
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    chk("rst_l3_read_enable", 64'(bus.l3_read_enable), 64'(0));
    @(negedge clk_in); #1;
    rst_in = 1'b0;
    repeat (6) @(negedge clk_in);
    #3;
    chk("late_resp_cyc", 64'(obs_cyc), 64'(-1));
    req_check(mk(1, 2, 3), -1, 7, 0, 5, 1);

    for (int n = 0; n < 150; n++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk_in);
      p = mk(pool[$urandom_range(0, 11)], pool[$urandom_range(0, 11)], pool[$urandom_range(0, 11)]);
      off = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      start_req(p, a, rc, miss);
      finish_req(p, a, rc, miss, off);
    end
    repeat (8) @(negedge clk_in);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
